// File: rtl/div_pkg.sv
//------------------------------------------------------------------------------
// Module  : div_pkg
// Brief   : Shared encodings and helpers for the multi-cycle divider.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package div_pkg;

    // Divider control states (encodings are fixed; other stages decode them)
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic        c_DIV_START          = 1'b1;
    localparam logic        c_DIV_STOP           = 1'b0;
    localparam logic        c_DIV_RESULT_READY   = 1'b1;
    localparam logic        c_DIV_RESULT_NOT_RDY = 1'b0;
    localparam logic [31:0] c_ZERO_WORD          = 32'h0000_0000;
    localparam logic [5:0]  c_DIV_STEPS          = 6'd32;

    // Magnitude of an operand; in signed mode a negative value is replaced by
    // its two's complement, so 0x80000000 maps onto itself as 2^31.
    function automatic logic [31:0] div_magnitude(input logic [31:0] value,
                                                  input logic        is_signed);
        div_magnitude = (is_signed && value[31]) ? (c_ZERO_WORD - value) : value;
    endfunction

endpackage : div_pkg

`default_nettype wire

// File: rtl/div.sv
//------------------------------------------------------------------------------
// Module  : div
// Brief   : 32-bit restoring divider, signed (DIV) / unsigned (DIVU), one
//           quotient bit per cycle. result_o = {remainder, quotient}.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module div
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_e  r_state;
    logic [5:0]  r_cnt;
    // [64:33] partial remainder, low bits hold remaining dividend bits and the
    // quotient bits shifted in from bit 0.
    logic [64:0] r_work;
    logic [31:0] r_divisor;
    logic        r_neg_quot;
    logic        r_neg_rem;

    logic        w_ge;
    logic [31:0] w_diff;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Trial subtract for the current step plus final sign correction.
    // The partial remainder is below 2*divisor, so the low 32 bits of the
    // difference are exact whenever the subtract is taken.
    always_comb begin
        w_ge   = (r_work[64:32] >= {1'b0, r_divisor});
        w_diff = r_work[63:32] - r_divisor;
        w_quot = r_neg_quot ? (c_ZERO_WORD - r_work[31:0])  : r_work[31:0];
        w_rem  = r_neg_rem  ? (c_ZERO_WORD - r_work[64:33]) : r_work[64:33];
    end

    // Control state, iteration counter, working register and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= DIV_FREE;
            r_cnt      <= 6'd0;
            r_work     <= 65'd0;
            r_divisor  <= c_ZERO_WORD;
            r_neg_quot <= 1'b0;
            r_neg_rem  <= 1'b0;
            ready_o    <= c_DIV_RESULT_NOT_RDY;
            result_o   <= {c_ZERO_WORD, c_ZERO_WORD};
        end else begin
            case (r_state)
                DIV_FREE: begin
                    ready_o  <= c_DIV_RESULT_NOT_RDY;
                    result_o <= {c_ZERO_WORD, c_ZERO_WORD};
                    if (start_i == c_DIV_START && !annul_i) begin
                        if (opdata2_i == c_ZERO_WORD) begin
                            r_state <= DIV_BY_ZERO;
                        end else begin
                            r_state    <= DIV_ON;
                            r_cnt      <= 6'd0;
                            r_work     <= {c_ZERO_WORD,
                                           div_magnitude(opdata1_i, signed_div_i),
                                           1'b0};
                            r_divisor  <= div_magnitude(opdata2_i, signed_div_i);
                            r_neg_quot <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                            r_neg_rem  <= signed_div_i & opdata1_i[31];
                        end
                    end
                end

                DIV_BY_ZERO: begin
                    if (annul_i) begin
                        r_state  <= DIV_FREE;
                        ready_o  <= c_DIV_RESULT_NOT_RDY;
                        result_o <= {c_ZERO_WORD, c_ZERO_WORD};
                    end else begin
                        r_state  <= DIV_END;
                        ready_o  <= c_DIV_RESULT_READY;
                        result_o <= {c_ZERO_WORD, c_ZERO_WORD};
                    end
                end

                DIV_ON: begin
                    if (annul_i) begin
                        r_state  <= DIV_FREE;
                        r_cnt    <= 6'd0;
                        ready_o  <= c_DIV_RESULT_NOT_RDY;
                        result_o <= {c_ZERO_WORD, c_ZERO_WORD};
                    end else if (r_cnt != c_DIV_STEPS) begin
                        r_cnt <= r_cnt + 6'd1;
                        if (w_ge) begin
                            r_work <= {w_diff, r_work[31:0], 1'b1};
                        end else begin
                            r_work <= {r_work[63:0], 1'b0};
                        end
                    end else begin
                        r_state  <= DIV_END;
                        r_cnt    <= 6'd0;
                        ready_o  <= c_DIV_RESULT_READY;
                        result_o <= {w_rem, w_quot};
                    end
                end

                DIV_END: begin
                    // annul_i is deliberately ignored: the result is final
                    if (start_i == c_DIV_STOP) begin
                        r_state  <= DIV_FREE;
                        ready_o  <= c_DIV_RESULT_NOT_RDY;
                        result_o <= {c_ZERO_WORD, c_ZERO_WORD};
                    end
                end

                default: begin
                    r_state  <= DIV_FREE;
                    ready_o  <= c_DIV_RESULT_NOT_RDY;
                    result_o <= {c_ZERO_WORD, c_ZERO_WORD};
                end
            endcase
        end
    end

endmodule : div

`default_nettype wire

// File: tb/tb_div.sv
//------------------------------------------------------------------------------
// Module  : tb_div
// Brief   : Scoreboard bench for div: stimulus pushes expected results and
//           latencies, an independent monitor pops them when ready_o rises.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div = 1'b0;
    logic [31:0] opdata1 = 32'd0;
    logic [31:0] opdata2 = 32'd0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [63:0] result;
    logic        ready;

    typedef struct {
        logic [63:0] res;
        int          t;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_total = 0;
    int   n_pass  = 0;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, n_pass=%0d n_total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input bit ok,
                       input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%016h, expected 0x%016h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference: plain integer division, quotient truncated toward zero
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        longint sa, sb2, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa  = longint'($signed(a));
            sb2 = longint'($signed(b));
            q   = sa / sb2;
            r   = sa % sb2;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    // Monitor: checks value and latency on ready rise, stability while held,
    // and zeroed result when ready drops.
    initial begin : monitor
        logic        prev_ready;
        logic [63:0] cur_exp;
        exp_t        e;
        prev_ready = 1'b0;
        cur_exp    = 64'd0;
        forever begin
            @(negedge clk);
            if (ready && !prev_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 1'b0, result, 64'd0);
                end else begin
                    e       = sb.pop_front();
                    cur_exp = e.res;
                    chk("result", result === e.res, result, e.res);
                    chk("latency", (cyc - e.t) == e.lat, 64'(cyc - e.t), 64'(e.lat));
                end
            end else if (ready && prev_ready) begin
                chk("result_hold", result === cur_exp, result, cur_exp);
            end else if (!ready && prev_ready) begin
                chk("result_clear", result === 64'd0, result, 64'd0);
            end
            prev_ready = ready;
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp, input int hold);
        exp_t e;
        int   n;
        @(negedge clk);
        opdata1    = a;
        opdata2    = b;
        signed_div = s;
        start      = 1'b1;
        e.res = exp;
        e.t   = cyc + 1;
        e.lat = (b == 32'd0) ? 1 : 33;
        sb.push_back(e);
        @(negedge clk);
        opdata1 = $urandom;
        opdata2 = $urandom;
        n = 0;
        while (!ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 1'b0, 64'(ready), 64'd1);
        repeat (hold) begin
            @(negedge clk);
            annul = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        annul = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin : stimulus
        logic [31:0] a, b;
        logic        s;
        bit          seen;

        repeat (3) @(negedge clk);
        chk("reset_ready", ready === 1'b0, 64'(ready), 64'd0);
        chk("reset_result", result === 64'd0, result, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases with hand-computed results
        issue(32'h0000_0064, 32'h0000_0007, 1'b0, 64'h00000002_0000000E, 2);
        issue(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 1);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h00000000_80000000, 0);
        issue(32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 64'h0000000F_0FFFFFFF, 1);
        issue(32'h1234_5678, 32'h0000_0000, 1'b0, 64'h0, 2);
        issue(32'h8000_0000, 32'h0000_0000, 1'b1, 64'h0, 0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 255));
                2:       b = 32'd0 - 32'($urandom_range(1, 255));
                default: b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> 16);
            endcase
            s = 1'($urandom_range(0, 1));
            issue(a, b, s, model(a, b, s), $urandom_range(0, 3));
        end

        // Annul part-way through a division: no result may appear
        @(negedge clk);
        opdata1 = 32'h1234_5678;
        opdata2 = 32'h0000_0011;
        signed_div = 1'b0;
        start = 1'b1;
        repeat (11) @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        chk("annul_no_ready", !seen, 64'(seen), 64'd0);
        chk("annul_result", result === 64'd0, result, 64'd0);

        // Reset mid-division, with start still asserted during reset
        @(negedge clk);
        opdata1 = 32'hDEAD_BEEF;
        opdata2 = 32'h0000_1234;
        start = 1'b1;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", ready === 1'b0, 64'(ready), 64'd0);
        chk("rst_result", result === 64'd0, result, 64'd0);
        start = 1'b0;
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        chk("rst_no_ready", !seen, 64'(seen), 64'd0);

        issue(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 1);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size() == 0, 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_div

`default_nettype wire
